// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO bridge.
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_PAGE     = 16'hFFFF;
  localparam logic [7:0]  OFF_CYCLE_LO  = 8'h00;
  localparam logic [7:0]  OFF_CYCLE_HI  = 8'h04;
  localparam logic [7:0]  OFF_TX_DATA   = 8'h08;
  localparam logic [7:0]  OFF_TX_STATUS = 8'h0C;

  // TX_STATUS bit positions
  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_COUNT_LSB = 3;

  typedef enum logic {
    REGION_RAM,
    REGION_MMIO
  } region_e;

  function automatic region_e decode_region(input logic [31:0] a);
    return (a[31:16] == MMIO_PAGE) ? REGION_MMIO : REGION_RAM;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_tx_fifo.sv
// Circular-buffer byte FIFO feeding the MMIO transmit drain port.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign valid   = !empty;
  assign head    = empty ? '0 : mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data RAM plus MMIO page (cycle counter, TX FIFO) on the core's memory stage.
// Optional alignment checking is enabled by defining DMEM_MMIO_ALIGN_CHECK_EN.
module dmem_mmio_bridge
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  region_e       region;
  logic [5:0]    word_off;
  logic          bad_access;
  logic          ram_we;
  logic          mmio_we;
  logic          push_req;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count_sat;
  logic [31:0]   status_word;
  logic [63:0]   cycle_cnt;
  logic          overflow;
  logic          unused_addr_bits;

  assign region           = decode_region(addr);
  assign ram_idx          = addr[AW+1:2];
  assign word_off         = addr[7:2];
  assign unused_addr_bits = ^addr;

`ifdef DMEM_MMIO_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (addr[1:0] != 2'b00);
  assign bad_access = misaligned && (we || region == REGION_MMIO);

  always_ff @(posedge clk) begin
    if (reset)           misalign_err <= 1'b0;
    else if (bad_access) misalign_err <= 1'b1;
  end
`else
  assign bad_access   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign ram_we   = we && (region == REGION_RAM) && !bad_access;
  assign mmio_we  = we && (region == REGION_MMIO) && !bad_access;
  assign push_req = mmio_we && (word_off == OFF_TX_DATA[7:2]);
  assign pop      = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)
      overflow <= 1'b1;
    else if (mmio_we && (word_off == OFF_TX_STATUS[7:2]))
      overflow <= 1'b0;
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .valid     (tx_valid),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    count_sat = 4'(fifo_count);
    if (32'(fifo_count) > 32'd15) count_sat = 4'hF;
    status_word                       = '0;
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_OVERFLOW]          = overflow;
    status_word[ST_COUNT_LSB +: 4]    = count_sat;
  end

  always_comb begin
    rdata = '0;
    if (!bad_access) begin
      if (region == REGION_RAM) begin
        rdata = ram[ram_idx];
      end else begin
        case (word_off)
          OFF_CYCLE_LO[7:2]:  rdata = cycle_cnt[31:0];
          OFF_CYCLE_HI[7:2]:  rdata = cycle_cnt[63:32];
          OFF_TX_STATUS[7:2]: rdata = status_word;
          default:            rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge: stimulus queues expectations, a monitor checks them.
module tb_dmem_mmio_bridge;

  localparam int K_RD  = 0;
  localparam int K_ERR = 1;
  localparam int K_TXV = 2;
  localparam int K_TXD = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        misalign_err;

  logic        chk_en = 1'b0;
  logic        rst_next = 1'b1;
  logic        rdy_next = 1'b0;
  exp_t        exp_q[$];
  logic [7:0]  tx_q[$];
  int          checks = 0;
  int          errors = 0;

  dmem_mmio_bridge #(.RAM_WORDS(64), .TX_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; optionally queue one expected value for this cycle.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input bit chk, input int kind, input logic [31:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    reset    = rst_next;
    tx_ready = rdy_next;
    addr     = a;
    we       = w;
    wdata    = d;
    chk_en   = chk;
    if (chk) begin
      x.kind = kind;
      x.exp  = e;
      x.nm   = nm;
      exp_q.push_back(x);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    cyc(a, 1'b0, 32'h0, 1'b1, K_RD, e, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, 1'b1, d, 1'b0, K_RD, 32'h0, "");
  endtask

  task automatic chk(input int kind, input logic [31:0] e, input string nm);
    cyc(32'h0, 1'b0, 32'h0, 1'b1, kind, e, nm);
  endtask

  task automatic idle();
    cyc(32'h0, 1'b0, 32'h0, 1'b0, K_RD, 32'h0, "");
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  eb;
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expectation queued");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_ERR:   act = {31'b0, misalign_err};
          K_TXV:   act = {31'b0, tx_valid};
          K_TXD:   act = {24'b0, tx_data};
          default: act = rdata;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
        end
      end
    end
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected_pop: got %h expected none", tx_data);
      end else begin
        eb = tx_q.pop_front();
        if (tx_data !== eb) begin
          errors++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, eb);
        end
      end
    end
  end

  initial begin
    // Reset state
    rst_next = 1'b1;
    rd(32'hFFFF_0000, 32'h0, "rst_cycle_lo");
    rd(32'hFFFF_000C, 32'h2, "rst_status");
    chk(K_TXV, 32'h0, "rst_tx_valid");
    chk(K_TXD, 32'h0, "rst_tx_data");
    chk(K_ERR, 32'h0, "rst_misalign");

    // Cycle counter starts at 0 in the first cycle after reset
    rst_next = 1'b0;
    rd(32'hFFFF_0000, 32'd0, "cycle_lo_0");
    rd(32'hFFFF_0000, 32'd1, "cycle_lo_1");
    rd(32'hFFFF_0000, 32'd2, "cycle_lo_2");
    rd(32'hFFFF_0000, 32'd3, "cycle_lo_3");
    rd(32'hFFFF_0004, 32'd0, "cycle_hi");
    rd(32'hFFFF_0010, 32'd0, "mmio_unmapped");

    // RAM write/read, aliasing, read-during-write
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    cyc(32'h0000_0010, 1'b1, 32'h1, 1'b1, K_RD, 32'hDEAD_BEEF, "ram_rdw_old");
    rd(32'h0000_0010, 32'h1, "ram_rdw_new");

    // Misaligned accesses
`ifdef DMEM_MMIO_ALIGN_CHECK_EN
    rd(32'hFFFF_000D, 32'h0, "mis_mmio_rd");
    wr(32'h0000_0012, 32'hCAFE_0000);
    rd(32'h0000_0010, 32'h1, "mis_wr_word4");
    chk(K_ERR, 32'h1, "mis_err_set");
    idle();
    chk(K_ERR, 32'h1, "mis_err_sticky");
`else
    rd(32'hFFFF_000D, 32'h2, "mis_mmio_rd");
    wr(32'h0000_0012, 32'hCAFE_0000);
    rd(32'h0000_0010, 32'hCAFE_0000, "mis_wr_word4");
    chk(K_ERR, 32'h0, "mis_err_tied");
`endif

    // Fill the FIFO past capacity with the sink stalled
    rdy_next = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      wr(32'hFFFF_0008, 32'h41 + i);
      if (i < 4) tx_q.push_back(8'(32'h41 + i));
    end
    rd(32'hFFFF_000C, 32'h25, "status_full_ovf");
    chk(K_TXD, 32'h41, "tx_head_stable");
    wr(32'hFFFF_000C, 32'h0);
    rd(32'hFFFF_000C, 32'h21, "status_ovf_clr");

    // Drain one byte per cycle
    rdy_next = 1'b1;
    for (int unsigned i = 0; i < 4; i++) idle();
    rd(32'hFFFF_000C, 32'h2, "status_drained");
    chk(K_TXV, 32'h0, "tx_valid_drained");

    // Push while full with a simultaneous pop
    rdy_next = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      wr(32'hFFFF_0008, 32'h61 + i);
      tx_q.push_back(8'(32'h61 + i));
    end
    rd(32'hFFFF_000C, 32'h21, "status_refill");
    rdy_next = 1'b1;
    wr(32'hFFFF_0008, 32'h55);
    tx_q.push_back(8'h55);
    rdy_next = 1'b0;
    rd(32'hFFFF_000C, 32'h21, "status_push_pop");
    rdy_next = 1'b1;
    for (int unsigned i = 0; i < 4; i++) idle();
    rd(32'hFFFF_000C, 32'h2, "status_drained2");

    // Reset mid-operation discards FIFO contents
    rdy_next = 1'b0;
    wr(32'hFFFF_0008, 32'h77);
    rst_next = 1'b1;
    rdy_next = 1'b1;
    idle();
    rst_next = 1'b0;
    rdy_next = 1'b0;
    rd(32'hFFFF_0000, 32'd0, "post_rst_cycle_lo");
    chk(K_TXV, 32'h0, "post_rst_tx_valid");
    rd(32'hFFFF_000C, 32'h2, "post_rst_status");
    chk(K_ERR, 32'h0, "post_rst_misalign");
    idle();

    for (int unsigned n = 0; n < 20 && (exp_q.size() != 0 || tx_q.size() != 0); n++)
      @(posedge clk);
    if (exp_q.size() != 0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_q.size(), tx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
